// File: rtl/tl_pkg.sv
// tl_pkg: shared state encodings and lamp patterns for the traffic-light controller.
package tl_pkg;
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR_A   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR_B   = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;
endpackage

// File: rtl/tick_timer.sv
// tick_timer: down-counter that loads on a strobe, decrements on tick and flags zero.
module tick_timer #(
    parameter int             TW      = 8,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);
    logic [TW-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road light sequencer with pedestrian walk phase.
// Optional NIGHT_MODE_EN adds a flashing-yellow night state driven by the night input.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int CLEAR_T  = 1,
    parameter int WALK_T   = 8,
    parameter int TW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state_o
);
    state_t        state, next_state;
    logic          zero, load, enter_walk;
    logic          flash_on, next_flash, ret_ew, pending, next_pending;
    logic [TW-1:0] load_val;
    logic [2:0]    next_ns, next_ew;

    function automatic logic [TW-1:0] dur_m1(state_t s);
        return (s == NS_GREEN  || s == EW_GREEN)  ? TW'(GREEN_T - 1)  :
               (s == NS_YELLOW || s == EW_YELLOW) ? TW'(YELLOW_T - 1) :
               s == PED_WALK ? TW'(WALK_T - 1) :
               s == FLASH    ? '0 : TW'(CLEAR_T - 1);
    endfunction

    tick_timer #(.TW(TW), .RST_VAL(TW'(CLEAR_T - 1))) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

`ifndef NIGHT_MODE_EN
    logic unused_night;
    assign unused_night = night;
`endif

    always_comb begin
        next_state = state;
        if (tick && zero)
            case (state)
                NS_GREEN:  next_state = NS_YELLOW;
                NS_YELLOW: next_state = CLEAR_A;
                CLEAR_A:   next_state = pending ? PED_WALK : EW_GREEN;
                EW_GREEN:  next_state = EW_YELLOW;
                EW_YELLOW: next_state = CLEAR_B;
                CLEAR_B:   next_state = pending ? PED_WALK : NS_GREEN;
                PED_WALK:  next_state = ret_ew ? EW_GREEN : NS_GREEN;
                default:   next_state = state;
            endcase
`ifdef NIGHT_MODE_EN
        if (tick)
            next_state = night ? FLASH : (state == FLASH ? CLEAR_B : next_state);
`endif
        load       = next_state != state;
        load_val   = dur_m1(next_state);
        enter_walk = next_state == PED_WALK && state != PED_WALK;
        // flashing starts lit on entry, then toggles on every tick spent in FLASH
        next_flash = next_state != FLASH ? 1'b0 : state != FLASH ? 1'b1 : flash_on ^ tick;
        next_pending = enter_walk ? 1'b0 : (ped_req && state != PED_WALK) ? 1'b1 : pending;
`ifdef NIGHT_MODE_EN
        if (state == FLASH || next_state == FLASH)
            next_pending = 1'b0;
`endif
        next_ns = next_state == NS_GREEN  ? LAMP_GRN :
                  next_state == NS_YELLOW ? LAMP_YEL :
                  next_state == FLASH     ? (next_flash ? LAMP_YEL : LAMP_OFF) : LAMP_RED;
        next_ew = next_state == EW_GREEN  ? LAMP_GRN :
                  next_state == EW_YELLOW ? LAMP_YEL :
                  next_state == FLASH     ? (next_flash ? LAMP_YEL : LAMP_OFF) : LAMP_RED;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= CLEAR_B;
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
            walk     <= 1'b0;
            ped_ack  <= 1'b0;
            pending  <= 1'b0;
            ret_ew   <= 1'b0;
            flash_on <= 1'b0;
        end else begin
            state    <= next_state;
            ns_light <= next_ns;
            ew_light <= next_ew;
            walk     <= next_state == PED_WALK;
            ped_ack  <= enter_walk;
            pending  <= next_pending;
            ret_ew   <= enter_walk ? state == CLEAR_A : ret_ew;
            flash_on <= next_flash;
        end

    assign state_o = state;
endmodule
